// File: rtl/galois_pow_dual.sv
// galois_pow_dual: two lockstep modular exponentiators (right-to-left square-and-multiply)
// sharing one control FSM, built on pipelined Barrett multipliers.

module galois_mult_barrett_sync #(
    parameter int                N_BITS        = 254,
    parameter logic [N_BITS-1:0] PRIME_MODULUS = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter logic [N_BITS:0]   BARRETT_R     = 255'h54a47462623a04a7ab074a58680730147144852009e880ae620703a6be1de925,
    parameter int                MULT_LATENCY  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    output logic [N_BITS-1:0] product
);
    localparam logic [N_BITS+1:0] P2 = {2'b00, PRIME_MODULUS};
    logic [N_BITS-1:0]   a_q, b_q, r;
    logic [2*N_BITS-1:0] x;
    logic [2*N_BITS+1:0] t;
    logic [N_BITS+1:0]   qp, r0, r1, r2;
    logic                unused_low;
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else if (load) begin
            a_q <= a;
            b_q <= b;
        end
    end
    // Barrett: quotient estimate is at most 2 short, so two conditional subtractions finish the reduction
    assign x          = (2*N_BITS)'(a_q) * (2*N_BITS)'(b_q);
    assign t          = (2*N_BITS+2)'(x[2*N_BITS-1:N_BITS-1]) * (2*N_BITS+2)'(BARRETT_R);
    assign qp         = (N_BITS+2)'(t[2*N_BITS+1:N_BITS+1]) * P2;
    assign r0         = x[N_BITS+1:0] - qp;
    assign r1         = r0 >= P2 ? r0 - P2 : r0;
    assign r2         = r1 >= P2 ? r1 - P2 : r1;
    assign r          = r2[N_BITS-1:0];
    assign unused_low = ^{t[N_BITS:0], r2[N_BITS+1:N_BITS]};
    generate
        if (MULT_LATENCY == 1) begin : g_comb
            assign product = r;
        end else begin : g_pipe
            logic [N_BITS-1:0] pipe [MULT_LATENCY-1];
            always_ff @(posedge clk) begin
                pipe[0] <= r;
                for (int i = 1; i < MULT_LATENCY - 1; i++) pipe[i] <= pipe[i-1];
            end
            assign product = pipe[MULT_LATENCY-2];
        end
    endgenerate
endmodule

module galois_pow_dual #(
    parameter int                N_BITS        = 254,
    parameter logic [N_BITS-1:0] PRIME_MODULUS = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter logic [N_BITS:0]   BARRETT_R     = 255'h54a47462623a04a7ab074a58680730147144852009e880ae620703a6be1de925,
    parameter int                EXP_BITS      = 254,
    parameter int                MULT_LATENCY  = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_BITS-1:0]   base_a,
    input  logic [N_BITS-1:0]   base_b,
    input  logic [EXP_BITS-1:0] exp_a,
    input  logic [EXP_BITS-1:0] exp_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N_BITS-1:0]   result_a,
    output logic [N_BITS-1:0]   result_b,
    output logic                busy
);
    localparam int CW = MULT_LATENCY > 1 ? $clog2(MULT_LATENCY) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state, state_next;
    logic [EXP_BITS-1:0] e_a, e_b;
    logic [N_BITS-1:0]   acc_a, acc_b, sq_a, sq_b, mul_a, mul_b, sqr_a, sqr_b;
    logic [CW-1:0]       cnt;
    logic                last, load;
    assign last = cnt == CW'(MULT_LATENCY - 1);
    assign load = state == ISSUE;
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = in_valid ? ISSUE : IDLE;
            ISSUE:   state_next = (e_a == '0 && e_b == '0) ? DONE : WAIT;
            WAIT:    state_next = last ? ISSUE : WAIT;
            DONE:    state_next = out_ready ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end
    always_comb begin
        in_ready  = state == IDLE;
        busy      = state != IDLE;
        out_valid = state == DONE;
        result_a  = out_valid ? acc_a : '0;
        result_b  = out_valid ? acc_b : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_a <= N_BITS'(1);
            acc_b <= N_BITS'(1);
            sq_a  <= '0;
            sq_b  <= '0;
            e_a   <= '0;
            e_b   <= '0;
            cnt   <= '0;
        end else if (state == IDLE && in_valid) begin
            acc_a <= N_BITS'(1);
            acc_b <= N_BITS'(1);
            sq_a  <= base_a;
            sq_b  <= base_b;
            e_a   <= exp_a;
            e_b   <= exp_b;
        end else if (state == ISSUE) begin
            cnt <= '0;
        end else if (state == WAIT) begin
            cnt <= cnt + CW'(1);
            // a channel whose exponent has run out keeps shifting zeros, so its acc holds
            if (last) begin
                sq_a  <= sqr_a;
                sq_b  <= sqr_b;
                acc_a <= e_a[0] ? mul_a : acc_a;
                acc_b <= e_b[0] ? mul_b : acc_b;
                e_a   <= e_a >> 1;
                e_b   <= e_b >> 1;
            end
        end
    end
    galois_mult_barrett_sync #(.N_BITS(N_BITS), .PRIME_MODULUS(PRIME_MODULUS), .BARRETT_R(BARRETT_R),
        .MULT_LATENCY(MULT_LATENCY)) u_mul_a (.clk(clk), .reset(reset), .load(load), .a(acc_a), .b(sq_a), .product(mul_a));
    galois_mult_barrett_sync #(.N_BITS(N_BITS), .PRIME_MODULUS(PRIME_MODULUS), .BARRETT_R(BARRETT_R),
        .MULT_LATENCY(MULT_LATENCY)) u_sqr_a (.clk(clk), .reset(reset), .load(load), .a(sq_a), .b(sq_a), .product(sqr_a));
    galois_mult_barrett_sync #(.N_BITS(N_BITS), .PRIME_MODULUS(PRIME_MODULUS), .BARRETT_R(BARRETT_R),
        .MULT_LATENCY(MULT_LATENCY)) u_mul_b (.clk(clk), .reset(reset), .load(load), .a(acc_b), .b(sq_b), .product(mul_b));
    galois_mult_barrett_sync #(.N_BITS(N_BITS), .PRIME_MODULUS(PRIME_MODULUS), .BARRETT_R(BARRETT_R),
        .MULT_LATENCY(MULT_LATENCY)) u_sqr_b (.clk(clk), .reset(reset), .load(load), .a(sq_b), .b(sq_b), .product(sqr_b));
endmodule

// File: tb/tb_galois_pow_dual.sv
// tb_galois_pow_dual: random and directed jobs on a full-size and an 8-bit instance,
// checked against modular-arithmetic reference functions.
module tb_galois_pow_dual;
    localparam logic [253:0] P = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
    localparam logic [253:0] E_INV5 = 254'h26b6a528b427b35493736af8679aad17535cb9d394945a0dcfe7f7a98ccccccd;
    logic clk = 0;
    always #5 clk = ~clk;
    logic         reset, in_valid, in_ready, out_valid, out_ready, busy;
    logic [253:0] base_a, base_b, exp_a, exp_b, result_a, result_b;
    logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
    logic [7:0]   s_base_a, s_base_b, s_exp_a, s_exp_b, s_result_a, s_result_b;
    int n_chk = 0, n_pass = 0;

    galois_pow_dual dut (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .base_a(base_a), .base_b(base_b), .exp_a(exp_a), .exp_b(exp_b), .out_valid(out_valid),
        .out_ready(out_ready), .result_a(result_a), .result_b(result_b), .busy(busy));
    galois_pow_dual #(.N_BITS(8), .PRIME_MODULUS(8'd251), .BARRETT_R(9'd261), .EXP_BITS(8), .MULT_LATENCY(1)) dut_s (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready), .base_a(s_base_a),
        .base_b(s_base_b), .exp_a(s_exp_a), .exp_b(s_exp_b), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .result_a(s_result_a), .result_b(s_result_b), .busy(s_busy));

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [253:0] mulmod(input logic [253:0] a, input logic [253:0] b);
        logic [507:0] t;
        t = {254'd0, a} * {254'd0, b};
        return 254'(t % {254'd0, P});
    endfunction

    function automatic logic [253:0] powmod(input logic [253:0] b, input logic [253:0] e);
        logic [253:0] r = 254'd1;
        for (int i = 0; i < 254; i++) begin
            if (e[i]) r = mulmod(r, b);
            b = mulmod(b, b);
        end
        return r;
    endfunction

    function automatic int rounds(input logic [253:0] v);
        int r = 0;
        for (int i = 0; i < 254; i++) if (v[i]) r = i + 1;
        return r;
    endfunction

    function automatic logic [253:0] rand_fe();
        logic [255:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return 254'(t % {2'b00, P});
    endfunction

    task automatic job(input logic [253:0] ba, input logic [253:0] bb, input logic [253:0] ea,
                       input logic [253:0] eb, input int hold, output logic [253:0] got_a);
        logic [253:0] ra, rb;
        int lat, lexp;
        ra = powmod(ba, ea);
        rb = powmod(bb, eb);
        lexp = rounds(ea | eb) * 13 + 2;
        @(negedge clk);
        base_a = ba; base_b = bb; exp_a = ea; exp_b = eb; in_valid = 1;
        check("in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 0;
        lat = 1;
        check("busy", busy, 1);
        while (!out_valid && lat < 4000) begin
            @(negedge clk);
            lat++;
        end
        got_a = result_a;
        check("latency", lat, lexp);
        check("result_a", result_a, ra);
        check("result_b", result_b, rb);
        for (int i = 0; i < hold; i++) begin
            in_valid = ~in_valid;
            base_a = rand_fe();
            @(negedge clk);
            check("hold_a", result_a, ra);
            check("hold_b", result_b, rb);
            check("hold_flags", {out_valid, in_ready}, 2'b10);
        end
        in_valid = 0;
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        check("release", {out_valid, in_ready, busy}, 3'b010);
    endtask

    task automatic job_s(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] ea, input logic [7:0] eb);
        int ra = 1, rb = 1, lat, lexp;
        for (int i = 0; i < int'(ea); i++) ra = (ra * int'(ba)) % 251;
        for (int i = 0; i < int'(eb); i++) rb = (rb * int'(bb)) % 251;
        lexp = rounds(254'(ea | eb)) * 2 + 2;
        @(negedge clk);
        s_base_a = ba; s_base_b = bb; s_exp_a = ea; s_exp_b = eb; s_in_valid = 1;
        check("s_in_ready", s_in_ready, 1);
        @(negedge clk);
        s_in_valid = 0;
        lat = 1;
        while (!s_out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("s_latency", lat, lexp);
        check("s_result_a", s_result_a, ra);
        check("s_result_b", s_result_b, rb);
        s_out_ready = 1;
        @(negedge clk);
        s_out_ready = 0;
    endtask

    initial begin
        logic [253:0] x, got;
        reset = 1; in_valid = 0; out_ready = 0; base_a = 0; base_b = 0; exp_a = 0; exp_b = 0;
        s_in_valid = 0; s_out_ready = 0; s_base_a = 0; s_base_b = 0; s_exp_a = 0; s_exp_b = 0;
        repeat (3) @(negedge clk);
        check("rst_flags", {in_ready, out_valid, busy}, 3'b100);
        check("rst_results", {result_a, result_b}, 0);
        check("s_rst_flags", {s_in_ready, s_out_valid, s_busy}, 3'b100);
        reset = 0;
        job(254'd3, 254'd7, 254'd5, 254'd0, 0, got);
        check("pow_3_5", got, 243);
        job(254'd0, rand_fe(), 254'd0, 254'd0, 0, got);
        check("zero_pow_zero", got, 1);
        x = rand_fe();
        job(powmod(x, 254'd5), x, E_INV5, 254'd5, 10, got);
        check("fifth_root", got, x);
        job(rand_fe(), rand_fe(), 254'($urandom_range(1, 65535)), 254'($urandom), 0, got);
        job(rand_fe(), rand_fe(), rand_fe(), 254'd1, 0, got);
        // abort a job during the second round's wait, then run a fresh one
        @(negedge clk);
        base_a = rand_fe(); base_b = rand_fe(); exp_a = 254'hff; exp_b = 254'h3; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (20) @(negedge clk);
        check("mid_wait_busy", busy, 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("abort_flags", {in_ready, out_valid, busy}, 3'b100);
        check("abort_results", {result_a, result_b}, 0);
        job(rand_fe(), rand_fe(), 254'd6, 254'd9, 0, got);
        job_s(8'd0, 8'd0, 8'd0, 8'd0);
        for (int e = 0; e < 256; e++) job_s(8'd2, 8'($urandom_range(0, 250)), 8'(e), 8'($urandom_range(0, 255)));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
